vga_plot_arbiter: RTL

//  Sole owner of the vga_adapter plot port (vga_x/vga_y/vga_colour/vga_write).
//  Two pixel requesters (r0 = scene renderer, r1 = HUD/overlay) share the port
//  via round-robin valid/ready arbitration. A built-in clear sequencer sweeps
//  the whole frame with one colour and blocks both requesters while it runs.

---
 rtl/vga_plot_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/vga_plot_arbiter.sv
// Round-robin owner of the vga_adapter plot port, with a built-in full-frame clear sequencer.
// Optional build macro PLOT_CLIP_EN: drop (but still accept) requester beats outside the visible frame.
module vga_plot_arbiter #(
    parameter int H_RES = 160,
    parameter int V_RES = 120,
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int C_W   = 3
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           r0_valid,
    input  logic [X_W-1:0] r0_x,
    input  logic [Y_W-1:0] r0_y,
    input  logic [C_W-1:0] r0_colour,
    output logic           r0_ready,
    input  logic           r1_valid,
    input  logic [X_W-1:0] r1_x,
    input  logic [Y_W-1:0] r1_y,
    input  logic [C_W-1:0] r1_colour,
    output logic           r1_ready,
    input  logic           clear_start,
    input  logic [C_W-1:0] clear_colour,
    output logic           clear_busy,
    output logic           clear_done,
    output logic           clipped,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [C_W-1:0] vga_colour,
    output logic           vga_write
);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t         r_state;
    logic           r_last_grant;
    logic [X_W-1:0] r_clr_x;
    logic [Y_W-1:0] r_clr_y;
    logic [C_W-1:0] r_clr_colour;
    logic [X_W-1:0] r_vga_x;
    logic [Y_W-1:0] r_vga_y;
    logic [C_W-1:0] r_vga_colour;
    logic           r_vga_write;
    logic           r_clear_busy;
    logic           r_clear_done;
    logic           r_clipped;

    logic           w_idle;
    logic           w_grant0;
    logic           w_grant1;
    logic           w_grant;
    logic [X_W-1:0] w_sel_x;
    logic [Y_W-1:0] w_sel_y;
    logic [C_W-1:0] w_sel_colour;
    logic           w_in_range;
    logic           w_x_last;
    logic           w_y_last;

    assign w_idle = (r_state == S_IDLE);

    // r_last_grant = 1 means r1 won last, so r0 has priority on a tie.
    assign w_grant0 = w_idle & r0_valid & (~r1_valid | r_last_grant);
    assign w_grant1 = w_idle & r1_valid & ~w_grant0;
    assign w_grant  = w_grant0 | w_grant1;

    assign w_sel_x      = w_grant1 ? r1_x      : r0_x;
    assign w_sel_y      = w_grant1 ? r1_y      : r0_y;
    assign w_sel_colour = w_grant1 ? r1_colour : r0_colour;

`ifdef PLOT_CLIP_EN
    assign w_in_range = (32'(w_sel_x) < H_RES) && (32'(w_sel_y) < V_RES);
`else
    assign w_in_range = 1'b1;
`endif

    assign w_x_last = (r_clr_x == X_W'(H_RES - 1));
    assign w_y_last = (r_clr_y == Y_W'(V_RES - 1));

    assign r0_ready   = w_grant0;
    assign r1_ready   = w_grant1;
    assign clear_busy = r_clear_busy;
    assign clear_done = r_clear_done;
    assign clipped    = r_clipped;
    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_vga_colour;
    assign vga_write  = r_vga_write;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_clr_x      <= '0;
            r_clr_y      <= '0;
            r_clr_colour <= '0;
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_vga_write  <= 1'b0;
            r_clear_busy <= 1'b0;
            r_clear_done <= 1'b0;
            r_clipped    <= 1'b0;
        end else begin
            r_vga_write  <= 1'b0;
            r_clear_done <= 1'b0;
            r_clipped    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_last_grant <= w_grant1;
                        if (w_in_range) begin
                            r_vga_x      <= w_sel_x;
                            r_vga_y      <= w_sel_y;
                            r_vga_colour <= w_sel_colour;
                            r_vga_write  <= 1'b1;
                        end else begin
                            r_clipped <= 1'b1;
                        end
                    end
                    if (clear_start) begin
                        r_state      <= S_CLEAR;
                        r_clear_busy <= 1'b1;
                        r_clr_x      <= '0;
                        r_clr_y      <= '0;
                        r_clr_colour <= clear_colour;
                    end
                end
                S_CLEAR: begin
                    r_vga_x      <= r_clr_x;
                    r_vga_y      <= r_clr_y;
                    r_vga_colour <= r_clr_colour;
                    r_vga_write  <= 1'b1;
                    if (w_x_last) begin
                        r_clr_x <= '0;
                        if (w_y_last) begin
                            r_state      <= S_IDLE;
                            r_clear_busy <= 1'b0;
                            r_clear_done <= 1'b1;
                            r_clr_y      <= '0;
                        end else begin
                            r_clr_y <= r_clr_y + 1'b1;
                        end
                    end else begin
                        r_clr_x <= r_clr_x + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
